main_ram_arbiter: RTL and testbench

- Sits directly upstream of main_ram. Arbitrates three bus masters onto main_ram's single-port slave bus (15-bit word address, 32-bit data, 4-bit byte select, 1-cycle registered read latency):
  - port 0: CPU/VRAM interface
  - port 1: layer renderer fetch
  - port 2: sprite renderer fetch
- Issues at most one access per clock, acknowledges it in the grant cycle, and routes the read data back one cycle later with a valid strobe.

---
 rtl/main_ram_pkg.sv | 32 +++
 rtl/rr_select3.sv | 40 ++++
 rtl/main_ram_arbiter.sv | 135 +++++++++++++
 tb/tb_main_ram_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/main_ram_pkg.sv
// ============================================================================
// Module   : main_ram_pkg
// Brief    : Shared constants and helpers for the main_ram arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package main_ram_pkg;

  localparam int ADDR_W_DEFAULT = 15;
  localparam int NUM_PORTS      = 3;

  localparam logic [1:0] PORT_CPU    = 2'd0;
  localparam logic [1:0] PORT_LAYER  = 2'd1;
  localparam logic [1:0] PORT_SPRITE = 2'd2;

  // Circular successor over the three ports (2 wraps to 0).
  function automatic logic [1:0] next_port(input logic [1:0] idx);
    return (idx >= PORT_SPRITE) ? PORT_CPU : idx + 2'd1;
  endfunction

  function automatic logic [1:0] onehot_to_port(input logic [NUM_PORTS-1:0] oh);
    logic [1:0] idx;
    idx = PORT_CPU;
    if (oh[1]) idx = PORT_LAYER;
    if (oh[2]) idx = PORT_SPRITE;
    return idx;
  endfunction

endpackage : main_ram_pkg

`default_nettype wire

// File: rtl/rr_select3.sv
// ============================================================================
// Module   : rr_select3
// Brief    : Combinational 3-way round-robin pick, one-hot grant output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_select3
  import main_ram_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic [1:0]           ptr,
  output logic [NUM_PORTS-1:0] grant
);

  // First requester at or after ptr in order 0->1->2->0; ptr=3 acts as 0.
  always_comb begin
    grant = '0;
    case (ptr)
      2'd1: begin
        if      (req[1]) grant = 3'b010;
        else if (req[2]) grant = 3'b100;
        else if (req[0]) grant = 3'b001;
      end
      2'd2: begin
        if      (req[2]) grant = 3'b100;
        else if (req[0]) grant = 3'b001;
        else if (req[1]) grant = 3'b010;
      end
      default: begin
        if      (req[0]) grant = 3'b001;
        else if (req[1]) grant = 3'b010;
        else if (req[2]) grant = 3'b100;
      end
    endcase
  end

endmodule : rr_select3

`default_nettype wire

// File: rtl/main_ram_arbiter.sv
// ============================================================================
// Module   : main_ram_arbiter
// Brief    : Three-master round-robin arbiter in front of main_ram.
//            Optional MAIN_RAM_ARB_CPU_PRIORITY_EN gives port 0 absolute priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module main_ram_arbiter
  import main_ram_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int RR_INIT = 0
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_strobe,
  input  logic              m0_write,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wrdata,
  input  logic [3:0]        m0_wrbytesel,
  output logic              m0_ack,
  output logic [31:0]       m0_rddata,
  output logic              m0_rddata_valid,

  input  logic              m1_strobe,
  input  logic              m1_write,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wrdata,
  input  logic [3:0]        m1_wrbytesel,
  output logic              m1_ack,
  output logic [31:0]       m1_rddata,
  output logic              m1_rddata_valid,

  input  logic              m2_strobe,
  input  logic              m2_write,
  input  logic [ADDR_W-1:0] m2_addr,
  input  logic [31:0]       m2_wrdata,
  input  logic [3:0]        m2_wrbytesel,
  output logic              m2_ack,
  output logic [31:0]       m2_rddata,
  output logic              m2_rddata_valid,

  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wrdata,
  output logic [3:0]        ram_wrbytesel,
  output logic              ram_write,
  input  logic [31:0]       ram_rddata
);

  localparam logic [1:0] PTR_RESET = (RR_INIT >= 0 && RR_INIT < NUM_PORTS) ?
                                     2'(RR_INIT) : PORT_CPU;

  logic [1:0]           rr_ptr;
  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] sel_req;
  logic [NUM_PORTS-1:0] sel_grant;
  logic [NUM_PORTS-1:0] grant;
  logic [1:0]           grant_idx;
  logic                 grant_write;
  logic                 ptr_update;
  logic                 rd_valid;
  logic [1:0]           rd_idx;

  assign req = {m2_strobe, m1_strobe, m0_strobe};

  rr_select3 u_rr_select3 (
    .req   (sel_req),
    .ptr   (rr_ptr),
    .grant (sel_grant)
  );

`ifdef MAIN_RAM_ARB_CPU_PRIORITY_EN
  // CPU wins outright; the pointer only rotates between the two renderers.
  assign sel_req    = {req[2:1], 1'b0};
  assign grant      = rst ? '0 : (req[0] ? 3'b001 : sel_grant);
  assign ptr_update = grant[1] | grant[2];
`else
  assign sel_req    = req;
  assign grant      = rst ? '0 : sel_grant;
  assign ptr_update = |grant;
`endif

  assign grant_idx = onehot_to_port(grant);

  // With no grant the bus carries master 0's request but ram_write stays low.
  always_comb begin
    ram_addr      = m0_addr;
    ram_wrdata    = m0_wrdata;
    ram_wrbytesel = m0_wrbytesel;
    grant_write   = m0_write;
    if (grant[1]) begin
      ram_addr      = m1_addr;
      ram_wrdata    = m1_wrdata;
      ram_wrbytesel = m1_wrbytesel;
      grant_write   = m1_write;
    end else if (grant[2]) begin
      ram_addr      = m2_addr;
      ram_wrdata    = m2_wrdata;
      ram_wrbytesel = m2_wrbytesel;
      grant_write   = m2_write;
    end
  end

  assign ram_write = (|grant) & grant_write;

  assign m0_ack = grant[0];
  assign m1_ack = grant[1];
  assign m2_ack = grant[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= PTR_RESET;
      rd_valid <= 1'b0;
      rd_idx   <= PORT_CPU;
    end else begin
      rd_valid <= (|grant) & ~grant_write;
      rd_idx   <= grant_idx;
      if (ptr_update) rr_ptr <= next_port(grant_idx);
    end
  end

  assign m0_rddata = ram_rddata;
  assign m1_rddata = ram_rddata;
  assign m2_rddata = ram_rddata;

  // Gating with rst drops a return that was in flight when reset arrived.
  assign m0_rddata_valid = rd_valid & ~rst & (rd_idx == PORT_CPU);
  assign m1_rddata_valid = rd_valid & ~rst & (rd_idx == PORT_LAYER);
  assign m2_rddata_valid = rd_valid & ~rst & (rd_idx == PORT_SPRITE);

endmodule : main_ram_arbiter

`default_nettype wire

// File: tb/tb_main_ram_arbiter.sv
// ============================================================================
// Module   : tb_main_ram_arbiter
// Brief    : Directed self-checking bench for main_ram_arbiter with a RAM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_main_ram_arbiter;

  localparam int ADDR_W = 15;

  logic clk = 1'b0;
  logic rst;

  logic              m0_strobe, m0_write, m1_strobe, m1_write, m2_strobe, m2_write;
  logic [ADDR_W-1:0] m0_addr, m1_addr, m2_addr;
  logic [31:0]       m0_wrdata, m1_wrdata, m2_wrdata;
  logic [3:0]        m0_wrbytesel, m1_wrbytesel, m2_wrbytesel;
  logic              m0_ack, m1_ack, m2_ack;
  logic [31:0]       m0_rddata, m1_rddata, m2_rddata;
  logic              m0_rddata_valid, m1_rddata_valid, m2_rddata_valid;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wrdata;
  logic [3:0]        ram_wrbytesel;
  logic              ram_write;
  logic [31:0]       ram_rddata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  main_ram_arbiter #(.ADDR_W(ADDR_W), .RR_INIT(0)) dut (
    .clk(clk), .rst(rst),
    .m0_strobe(m0_strobe), .m0_write(m0_write), .m0_addr(m0_addr),
    .m0_wrdata(m0_wrdata), .m0_wrbytesel(m0_wrbytesel), .m0_ack(m0_ack),
    .m0_rddata(m0_rddata), .m0_rddata_valid(m0_rddata_valid),
    .m1_strobe(m1_strobe), .m1_write(m1_write), .m1_addr(m1_addr),
    .m1_wrdata(m1_wrdata), .m1_wrbytesel(m1_wrbytesel), .m1_ack(m1_ack),
    .m1_rddata(m1_rddata), .m1_rddata_valid(m1_rddata_valid),
    .m2_strobe(m2_strobe), .m2_write(m2_write), .m2_addr(m2_addr),
    .m2_wrdata(m2_wrdata), .m2_wrbytesel(m2_wrbytesel), .m2_ack(m2_ack),
    .m2_rddata(m2_rddata), .m2_rddata_valid(m2_rddata_valid),
    .ram_addr(ram_addr), .ram_wrdata(ram_wrdata), .ram_wrbytesel(ram_wrbytesel),
    .ram_write(ram_write), .ram_rddata(ram_rddata)
  );

  // Behavioural main_ram: byte-masked writes, registered one-cycle read.
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    ram_rddata <= mem[ram_addr];
    if (ram_write) begin
      for (int b = 0; b < 4; b++)
        if (ram_wrbytesel[b]) mem[ram_addr][8*b +: 8] <= ram_wrdata[8*b +: 8];
    end
  end

  wire [2:0] acks   = {m2_ack, m1_ack, m0_ack};
  wire [2:0] valids = {m2_rddata_valid, m1_rddata_valid, m0_rddata_valid};

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int n, input logic s, input logic w,
                       input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] b);
    case (n)
      0: begin m0_strobe = s; m0_write = w; m0_addr = a; m0_wrdata = d; m0_wrbytesel = b; end
      1: begin m1_strobe = s; m1_write = w; m1_addr = a; m1_wrdata = d; m1_wrbytesel = b; end
      default: begin m2_strobe = s; m2_write = w; m2_addr = a; m2_wrdata = d; m2_wrbytesel = b; end
    endcase
  endtask

  task automatic idle();
    for (int n = 0; n < 3; n++) drive(n, 1'b0, 1'b0, '0, 32'h0, 4'h0);
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen 3 units later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

`ifdef MAIN_RAM_ARB_CPU_PRIORITY_EN
  localparam int NFAIR = 7;
  logic [2:0] fair_req [NFAIR] = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b110, 3'b110, 3'b110};
  logic [2:0] fair_ack [NFAIR] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b100, 3'b010};
  logic [2:0] fair_vld [NFAIR] = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b100};
`else
  localparam int NFAIR = 5;
  logic [2:0] fair_req [NFAIR] = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111};
  logic [2:0] fair_ack [NFAIR] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
  logic [2:0] fair_vld [NFAIR] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b001};
`endif

  initial begin
    rst = 1'b1;
    idle();
    drive(0, 1'b1, 1'b1, 15'h0, 32'h0, 4'hF);
    drive(1, 1'b1, 1'b0, 15'h0, 32'h0, 4'h0);
    drive(2, 1'b1, 1'b0, 15'h0, 32'h0, 4'h0);
    repeat (2) @(posedge clk);
    #4;
    check_val("reset_acks", 64'(acks), 64'h0);
    check_val("reset_ram_write", 64'(ram_write), 64'h0);
    check_val("reset_valids", 64'(valids), 64'h0);

    // Round-robin fairness (or CPU priority) from RR_INIT=0.
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < NFAIR; i++) begin
      if (i != 0) next_cycle();
      drive(0, fair_req[i][0], 1'b0, 15'h0, 32'h0, 4'h0);
      drive(1, fair_req[i][1], 1'b0, 15'h0, 32'h0, 4'h0);
      drive(2, fair_req[i][2], 1'b0, 15'h0, 32'h0, 4'h0);
      #3;
      check_val($sformatf("fair_ack_%0d", i), 64'(acks), 64'(fair_ack[i]));
      check_val($sformatf("fair_vld_%0d", i), 64'(valids), 64'(fair_vld[i]));
    end

    next_cycle(); idle(); #3;
    check_val("idle_acks", 64'(acks), 64'h0);
    check_val("idle_ram_write", 64'(ram_write), 64'h0);

    // m0 writes 0xDEADBEEF @0x1234, m1 reads it back.
    next_cycle(); idle(); drive(0, 1'b1, 1'b1, 15'h1234, 32'hDEADBEEF, 4'hF); #3;
    check_val("wr0_ack", 64'(acks), 64'h1);
    check_val("wr0_ram_write", 64'(ram_write), 64'h1);
    check_val("wr0_ram_addr", 64'(ram_addr), 64'h1234);
    check_val("wr0_ram_wrdata", 64'(ram_wrdata), 64'hDEADBEEF);
    next_cycle(); idle(); #3;
    check_val("wr0_no_valid", 64'(valids), 64'h0);
    next_cycle(); drive(1, 1'b1, 1'b0, 15'h1234, 32'h0, 4'h0); #3;
    check_val("rd1_ack", 64'(acks), 64'h2);
    check_val("rd1_ram_write", 64'(ram_write), 64'h0);
    next_cycle(); idle(); #3;
    check_val("rd1_valid", 64'(valids), 64'h2);
    check_val("rd1_data", 64'(m1_rddata), 64'hDEADBEEF);
    next_cycle(); #3;
    check_val("rd1_single_pulse", 64'(valids), 64'h0);

    // Byte-masked write into the upper block.
    next_cycle(); drive(2, 1'b1, 1'b1, 15'h4000, 32'hFFFFFFFF, 4'hF); #3;
    check_val("wr2a_ack", 64'(acks), 64'h4);
    next_cycle(); drive(2, 1'b1, 1'b1, 15'h4000, 32'h11223344, 4'b0101); #3;
    check_val("wr2b_bytesel", 64'(ram_wrbytesel), 64'h5);
    next_cycle(); drive(2, 1'b1, 1'b0, 15'h4000, 32'h0, 4'h0); #3;
    check_val("rd2_ack", 64'(acks), 64'h4);
    check_val("rd2_no_valid_after_write", 64'(valids), 64'h0);
    next_cycle(); idle(); #3;
    check_val("rd2_valid", 64'(valids), 64'h4);
    check_val("rd2_data", 64'(m2_rddata), 64'hFF22FF44);

    // Back-to-back reads, then a write right after a read.
    next_cycle(); drive(0, 1'b1, 1'b1, 15'h1, 32'hA1A1A1A1, 4'hF);
    next_cycle(); drive(0, 1'b1, 1'b1, 15'h2, 32'hB2B2B2B2, 4'hF);
    next_cycle(); drive(0, 1'b1, 1'b0, 15'h1, 32'h0, 4'h0); #3;
    check_val("b2b_t0_ack", 64'(acks), 64'h1);
    next_cycle(); idle(); drive(1, 1'b1, 1'b0, 15'h2, 32'h0, 4'h0); #3;
    check_val("b2b_t1_ack", 64'(acks), 64'h2);
    check_val("b2b_t1_valid", 64'(valids), 64'h1);
    check_val("b2b_t1_data", 64'(m0_rddata), 64'hA1A1A1A1);
    next_cycle(); idle(); drive(2, 1'b1, 1'b1, 15'h3, 32'h12345678, 4'hF); #3;
    check_val("b2b_t2_ack", 64'(acks), 64'h4);
    check_val("b2b_t2_ram_write", 64'(ram_write), 64'h1);
    check_val("b2b_t2_valid", 64'(valids), 64'h2);
    check_val("b2b_t2_data", 64'(m1_rddata), 64'hB2B2B2B2);
    next_cycle(); idle(); #3;
    check_val("b2b_t3_valid", 64'(valids), 64'h0);

    // Reset right after a read grant kills the return and restores the pointer.
    next_cycle(); drive(1, 1'b1, 1'b0, 15'h2, 32'h0, 4'h0); #3;
    check_val("rst_rd_ack", 64'(acks), 64'h2);
    next_cycle(); idle(); rst = 1'b1; #3;
    check_val("rst_suppress_valid", 64'(valids), 64'h0);
    check_val("rst_acks", 64'(acks), 64'h0);
    next_cycle(); rst = 1'b0;
    drive(1, 1'b1, 1'b0, 15'h0, 32'h0, 4'h0);
    drive(2, 1'b1, 1'b0, 15'h0, 32'h0, 4'h0); #3;
    check_val("post_rst_grant", 64'(acks), 64'h2);
    check_val("post_rst_valid", 64'(valids), 64'h0);

    next_cycle(); idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_main_ram_arbiter

`default_nettype wire
